// File: rtl/wallace_ctrl_pkg.sv
// wallace_ctrl_pkg: states, per-step digit/shift constants and carry-save helper for wallace_mul16_seq
package wallace_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    localparam int STEP_W = 2;
    localparam logic [3:0][4:0] STEP_SHIFT = {5'd16, 5'd8, 5'd8, 5'd0};
    localparam logic [3:0] STEP_A_HI = 4'b1010;
    localparam logic [3:0] STEP_B_HI = 4'b1100;
    typedef struct packed {
        logic [15:0] s;
        logic [15:0] c;
    } csa_t;
    function automatic csa_t csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        return {x ^ y ^ z, ((x & y) | (x & z) | (y & z)) << 1};
    endfunction
endpackage

// File: rtl/wallace_mul16_seq_core.sv
// wallace_mul16_seq_core: combinational unsigned 8x8 Wallace-tree multiplier
module wallace_mul16_seq_core
    import wallace_ctrl_pkg::*;
(
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] p
);
    logic [7:0][15:0] pp;
    csa_t l0, l1, l2, l3, l4, l5;
    always_comb begin
        for (int i = 0; i < 8; i++) pp[i] = y[i] ? 16'(x) << i : 16'd0;
    end
    // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add
    assign l0 = csa(pp[0], pp[1], pp[2]);
    assign l1 = csa(pp[3], pp[4], pp[5]);
    assign l2 = csa(l0.s, l0.c, l1.s);
    assign l3 = csa(l1.c, pp[6], pp[7]);
    assign l4 = csa(l2.s, l2.c, l3.s);
    assign l5 = csa(l4.s, l4.c, l3.c);
    assign p = l5.s + l5.c;
endmodule

// File: rtl/wallace_mul16_seq.sv
// wallace_mul16_seq: 16x16 multiplier sequencing four digit products through one shared 8x8 core
module wallace_mul16_seq
    import wallace_ctrl_pkg::*;
#(
    parameter int CORE_W = 8,
    parameter bit EARLY_ZERO = 1'b1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);
    state_t state, nxt;
    logic [STEP_W-1:0] step;
    logic [15:0] ar, br, prod;
    logic [31:0] acc, sum;
    logic accept, zero, last;
    if (CORE_W != 8) begin : g_bad_core_w
        $error("wallace_mul16_seq supports only CORE_W=8");
    end
    assign in_ready = state == IDLE || (state == DONE && out_ready);
    assign accept = in_valid && in_ready;
    assign zero = EARLY_ZERO && (a == 16'd0 || b == 16'd0);
    assign last = step == STEP_W'(3);
    assign out_valid = state == DONE;
    assign busy = state == MUL;
    wallace_mul16_seq_core u_core (
        .x(STEP_A_HI[step] ? ar[15:8] : ar[7:0]),
        .y(STEP_B_HI[step] ? br[15:8] : br[7:0]),
        .p(prod)
    );
    assign sum = acc + ({16'd0, prod} << STEP_SHIFT[step]);
    always_comb begin
        nxt = accept ? (zero ? DONE : MUL) : state == MUL ? (last ? DONE : MUL) : (state == DONE && out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    // result is only loaded on completion so it holds the last product through IDLE and the next MUL
    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
            acc <= '0;
            result <= '0;
            ar <= '0;
            br <= '0;
        end else if (accept) begin
            ar <= a;
            br <= b;
            acc <= '0;
            step <= '0;
            if (zero) result <= '0;
        end else if (state == MUL) begin
            acc <= sum;
            step <= step + 1'b1;
            if (last) result <= sum;
        end
    end
endmodule

// File: tb/tb_wallace_mul16_seq.sv
// tb_wallace_mul16_seq: directed and random scoreboard bench for wallace_mul16_seq
module tb_wallace_mul16_seq;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, v0 = 1'b0, r0 = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic in_ready, out_valid, busy, rdy0, ov0, busy0, took;
    logic [31:0] result, res0;
    logic [31:0] q[$];
    int total = 0, bad = 0, cycles = 0;

    always #5 clk = ~clk;

    wallace_mul16_seq u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );
    wallace_mul16_seq #(.EARLY_ZERO(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .a(a), .b(b),
        .out_valid(ov0), .out_ready(r0), .result(res0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // one clock: score handshakes seen before the edge, then advance to just after the edge
    task automatic cyc();
        #1;
        took = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 32'(q.size()), 32'd1);
            else chk("sb_result", result, q.pop_front());
        end
        if (took) q.push_back(32'(a) * 32'(b));
        @(posedge clk);
        #1;
        if (++cycles > 90000) begin
            $display("FAIL timeout: cycles=%0d limit=90000", cycles);
            $fatal(1);
        end
    endtask

    task automatic wait_out(input string tag, input int lat);
        int n = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n), 32'(lat));
    endtask

    task automatic op(input logic [15:0] x, input logic [15:0] y, input int lat, input logic [31:0] exp, input string tag);
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk({tag, "_acc"}, 32'(took), 32'd1);
        in_valid = 1'b0;
        wait_out({tag, "_lat"}, lat);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        cyc();
    endtask

    initial begin
        int n;
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);

        a = 16'h1234;
        b = 16'h5678;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("mul_rdy", 32'(in_ready), 32'd0);
            chk("mul_busy", 32'(busy), 32'd1);
            chk("mul_ov", 32'(out_valid), 32'd0);
            cyc();
        end
        chk("t1_ov", 32'(out_valid), 32'd1);
        chk("t1_res", result, 32'h06260060);
        chk("t1_busy", 32'(busy), 32'd0);
        cyc();

        op(16'hFFFF, 16'hFFFF, 4, 32'hFFFE0001, "ffff");
        op(16'h00FF, 16'hFF00, 4, 32'h00FE0100, "ff_ff00");
        op(16'h0000, 16'hABCD, 0, 32'h0, "zero_bypass");

        a = 16'h0000;
        b = 16'hABCD;
        chk("ez0_rdy", 32'(rdy0), 32'd1);
        v0 = 1'b1;
        r0 = 1'b1;
        cyc();
        v0 = 1'b0;
        chk("ez0_busy", 32'(busy0), 32'd1);
        n = 0;
        while (!ov0 && n < 20) begin
            cyc();
            n++;
        end
        chk("ez0_lat", 32'(n), 32'd4);
        chk("ez0_res", res0, 32'd0);
        cyc();

        a = 16'h1234;
        b = 16'h5678;
        in_valid = 1'b1;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        wait_out("bp_lat", 4);
        for (int k = 0; k < 3; k++) begin
            chk("bp_res", result, 32'h06260060);
            chk("bp_ov", 32'(out_valid), 32'd1);
            chk("bp_rdy", 32'(in_ready), 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'd2;
        b = 16'd3;
        cyc();
        chk("bp_accept", 32'(took), 32'd1);
        in_valid = 1'b0;
        wait_out("bp2_lat", 4);
        chk("bp2_res", result, 32'h00000006);
        cyc();

        a = 16'hFFFF;
        b = 16'hFFFF;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cyc();
        q.delete();
        rst = 1'b0;
        chk("mid_ov", 32'(out_valid), 32'd0);
        chk("mid_res", result, 32'd0);
        chk("mid_rdy", 32'(in_ready), 32'd1);
        chk("mid_busy0", 32'(busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("mid_no_ov", 32'(out_valid), 32'd0);
            cyc();
        end
        op(16'h0003, 16'h0005, 4, 32'h0000000F, "after_rst");

        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 15) == 0) a = '0;
            if ($urandom_range(0, 15) == 0) b = '0;
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                out_ready = $urandom_range(0, 7) != 0;
                cyc();
            end
            in_valid = 1'b1;
            do begin
                out_ready = $urandom_range(0, 7) != 0;
                cyc();
            end while (!took);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        repeat (3) cyc();
        chk("idle_after", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wallace_mul16_seq.md
Name: wallace_mul16_seq

Overview:
- Multi-cycle unsigned 16x16 -> 32 multiplier built around one shared instance of the existing combinational 8x8 Wallace tree core.
- An FSM feeds the four 8-bit digit products (aL*bL, aH*bL, aL*bH, aH*bH) through the core, one per cycle, and shifts and accumulates them.
- Input and output sides use valid/ready handshakes. It sits between an issuing datapath and the shared multiplier resource.

Parameters:
- CORE_W, 8, operand width of the shared core. Only 8 is supported; any other value is an elaboration error.
- EARLY_ZERO, 1, when 1 a zero operand bypasses the core and completes in one cycle.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  16  multiplicand, unsigned
- b  input  16  multiplier, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- result  output  32  product a*b
- busy  output  1  high in MUL state

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, step=0, acc=0, result=0, out_valid=0, busy=0, operand registers=0. Reset has priority over every event. Reset mid-MUL or mid-DONE discards the operation; no out_valid follows.
- States: IDLE, MUL, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational, with no dependency on in_valid.
- Accept = in_valid & in_ready at an edge. On accept, register a and b, clear acc, and set step=0.
  - Next state is MUL.
  - With EARLY_ZERO=1 and (a==0 | b==0), next state is DONE with acc=0.
- MUL step selection, core inputs muxed from registered operands:
  - step0: aL*bL, shift 0
  - step1: aH*bL, shift 8
  - step2: aL*bH, shift 8
  - step3: aH*bH, shift 16
- Each MUL edge: acc <= acc + (core_out << shift), 32-bit, and step increments. No overflow is possible because the final sum is at most 0xFFFE0001.
- After the step3 edge, state becomes DONE.
- Latency: accept at edge E0; out_valid is high after edge E4, i.e. 4 cycles. The zero bypass has 1-cycle latency.
- DONE: out_valid=1 and result=acc.
  - result stays stable while out_valid & !out_ready, for an unbounded stall.
  - On out_ready: if a new accept happens in the same cycle, go to MUL (or DONE for a zero bypass); otherwise go to IDLE. out_valid drops only when no new zero-bypass op is accepted.
- Back-to-back throughput: one result per 5 cycles with out_ready held high.
- Unaccepted operand changes (in_valid=0, or in_ready=0) have no effect.
- in_valid during MUL is ignored. The requester must hold in_valid and operands until accepted.
- result holds the last value in IDLE. It is cleared only by reset.
- busy = (state==MUL).

Decomposition:
- Package wallace_ctrl_pkg holds:
  - state enum {IDLE, MUL, DONE}
  - STEP_W=2
  - per-step shift constants {0,8,8,16}
  - per-step half-select constants
- Sub-module: the existing 8x8 core, instantiated once as u_core (inputs muxed, output 16 bits). No other sub-modules.
- FSM, operand registers, digit mux and accumulator are in this module.

Test Plan:
- Reset, then a=0x1234, b=0x5678, out_ready=1: in_ready=0 for 4 cycles; out_valid after E4 with result=0x06260060; busy high exactly 4 cycles.
- a=0xFFFF, b=0xFFFF: result=0xFFFE0001. Repeat with a=0x00FF, b=0xFF00, expecting result=0x00FE0100.
- EARLY_ZERO=1, a=0x0000, b=0xABCD: out_valid one cycle after accept with result=0, busy never high. With EARLY_ZERO=0: 4-cycle latency, result=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE. result stays at 0x06260060, out_valid=1, in_ready=0. Raising out_ready with in_valid=1 (a=2, b=3) accepts the next op in the same cycle; the next result is 0x00000006.
- Reset mid-MUL: assert rst on step2 of a=0xFFFF*0xFFFF. Next cycle state is IDLE, out_valid=0, result=0, in_ready=1. A following 0x0003*0x0005 yields 0x0000000F.
- Random soak: 10k random a/b with random out_ready and in_valid gaps; each result equals a*b, no dropped or duplicated transactions.
